tt_uart_tx: RTL and testbench

// - Outbound serial link for the Tiny Tapeout project: accepts result bytes from core logic over valid/ready.
// - Buffers accepted bytes in a small FIFO and shifts each one out on a single output pin as 8N1 UART, LSB first.
// - Counterpart to the project's parallel pin inputs: results leave the chip one serial byte at a time on uo_out[0].

---
 rtl/tt_uart_pkg.sv | 15 +
 rtl/tt_uart_tx_fifo.sv | 62 ++++++
 rtl/tt_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_tt_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the Tiny Tapeout 8N1 UART transmitter.
package tt_uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/tt_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter; pushes when full and pops
// when empty are ignored, pointers wrap modulo DEPTH.
module tt_uart_tx_fifo
    import tt_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [UART_DATA_W-1:0] din_i,
    output logic [UART_DATA_W-1:0] dout_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; flushing the pointers is enough to empty it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// 8N1 UART transmitter with a small input FIFO, LSB first on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11 bit times).
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1),
    localparam int BAUD_W = $clog2(CLKS_PER_BIT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_o,
    output logic                   busy,
    output logic [CNT_W-1:0]       fifo_count
);

    uart_tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic                   push;
    logic                   pop;
    logic                   baud_last;
    logic                   tx_line;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign tx_ready  = ~fifo_full;
    assign push      = tx_valid & ~fifo_full;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy      = (state_q != IDLE);
    assign tx_o      = tx_line;

    tt_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (tx_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    // The baud counter restarts on every state change so each bit lasts
    // exactly CLKS_PER_BIT cycles, including STOP->START with no idle gap.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_line = UART_IDLE_LVL;
        case (state_q)
            START:   tx_line = 1'b0;
            DATA:    tx_line = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_line = parity_q;
`endif
            default: tx_line = UART_IDLE_LVL;
        endcase
    end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Directed bench for tt_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_tt_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_o;
    logic       busy;
    logic [2:0] fifo_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits, bit 0 first on the wire
        logic       par;
    } vec_t;

    vec_t vecs[6];

    tt_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_o       (tx_o),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] line_of(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    // Called just before the negedge of the first START cycle.
    task automatic check_frame(input logic [10:0] line, input string name);
        for (int c = 0; c < FB * CPB; c++) begin
            @(negedge clk);
            if (c == 0) check({name, " busy"}, busy, 1);
            check($sformatf("%s bit%0d cyc%0d", name, c / CPB, c % CPB), tx_o, line[c / CPB]);
        end
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        while ((busy || fifo_count != 0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) check({name, " idle timeout"}, busy, 0);
    endtask

    // Independent line decoder used while the FIFO is under pressure.
    always begin
        @(negedge clk);
        if (mon_en && tx_o == 1'b0) begin
            logic [7:0] b;
            repeat (2) @(negedge clk);
            check("mon start", tx_o, 0);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                b[k] = tx_o;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            check("mon parity", tx_o, ^b);
`endif
            repeat (CPB) @(negedge clk);
            check("mon stop", tx_o, 1);
            rx_q.push_back(b);
        end
    end

    initial begin
        logic [7:0] ov[6];
        logic       rdy;
        logic       accepted;
        int         lows;

        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h3C, 10'h278, 1'b0};
        vecs[4] = '{8'h07, 10'h20E, 1'b1};
        vecs[5] = '{8'h03, 10'h206, 1'b0};
        ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset hold
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst tx_o", tx_o, 1);
        check("rst busy", busy, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst tx_ready", tx_ready, 1);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            wait_idle("vec");
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = vecs[i].data;
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
            check($sformatf("vec%0d pre-start tx_o", i), tx_o, 1);
            check($sformatf("vec%0d count after push", i), fifo_count, 1);
            check($sformatf("vec%0d pre-start busy", i), busy, 0);
            check_frame(line_of(vecs[i]), $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d end busy", i), busy, 0);
            check($sformatf("vec%0d end tx_o", i), tx_o, 1);
            check($sformatf("vec%0d end count", i), fifo_count, 0);
        end

        // Back-to-back 0x00 then 0xFF with no idle gap
        wait_idle("b2b");
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        check("b2b pre-start tx_o", tx_o, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(line_of(vecs[1]), "b2b first");
        check_frame(line_of(vecs[2]), "b2b second");
        @(negedge clk);
        check("b2b end busy", busy, 0);

        // Overflow pressure with tx_valid held high
        wait_idle("ovf");
        rx_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            accepted = 1'b0;
            for (int w = 0; w < 300 && !accepted; w++) begin
                @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = ov[i];
                if (i == 5 && w == 0) begin
                    check("ovf full tx_ready", tx_ready, 0);
                    check("ovf full count", fifo_count, DEPTH);
                end
                rdy = tx_ready;
                @(posedge clk);
                accepted = rdy;
            end
            if (!accepted) check($sformatf("ovf push%0d accepted", i), 0, 1);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        for (int w = 0; w < 400 && rx_q.size() < 6; w++) @(negedge clk);
        check("ovf rx count", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check($sformatf("ovf rx byte%0d", i), rx_q[i], ov[i]);
        mon_en = 1'b0;
        wait_idle("ovf end");
        check("ovf end busy", busy, 0);

        // Reset during DATA bit 3 with bytes still queued
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("mid bit3 tx_o", tx_o, 0);
        check("mid queued count", fifo_count, 2);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst tx_o", tx_o, 1);
        check("mid rst busy", busy, 0);
        check("mid rst count", fifo_count, 0);
        check("mid rst tx_ready", tx_ready, 1);
        rst  = 1'b0;
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("mid residual activity cycles", lows, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
